// File: rtl/kbest_pkg.sv
// Shared types and sizing for the k-best result SRAM array controller.
//   DATA_WIDTH/K/ADDR_WIDTH/DEPTH size the K-bank array.
//   SENTINEL is the "worst distance" value written by an array clear.
//   wr_state_e / rd_state_e are the write-path and readout FSM encodings.
//   beat_t is one readout beat: entry data, SRAM address and bank rank.
package kbest_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int K          = 4;
  localparam int ADDR_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
  localparam int RANK_W     = $clog2(K);
  // Beat counter must hold DEPTH*K without overflowing.
  localparam int BEAT_W     = ADDR_WIDTH + 1 + RANK_W;

  localparam logic [DATA_WIDTH-1:0] SENTINEL = '1;

  typedef enum logic {
    IDLE,
    CLEAR
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_RUN,
    R_DRAIN
  } rd_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic [RANK_W-1:0]     rank;
  } beat_t;

  // Active-low one-hot bank select for port1.
  function automatic logic [K-1:0] bank_sel_b(input logic [RANK_W-1:0] rank);
    return ~(K'(1) << rank);
  endfunction

endpackage

// File: rtl/kbest_out_skid.sv
// Two-entry valid/ready FIFO of beat_t feeding the readout stream.
//   clk, rst     : clock, synchronous active-high reset
//   push, in_beat: write one beat (caller guarantees space via count)
//   out_ready    : downstream accept; pop = out_valid && out_ready
//   out_valid    : head entry present
//   out_beat     : head entry, held stable until popped
//   count        : current occupancy 0..2
module kbest_out_skid
  import kbest_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  beat_t      in_beat,
  input  logic       out_ready,
  output logic       out_valid,
  output beat_t      out_beat,
  output logic [1:0] count
);

  beat_t mem [2];
  logic  wr_ptr;
  logic  rd_ptr;
  logic  pop;

  assign out_valid = (count != 2'd0);
  assign out_beat  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_beat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/kbest_array_ctrl.sv
// Sequencer/arbiter for the K-bank k-best result SRAM array.
// Port0 carries writer results and array clears; port1 serves readout,
// which serialises each address as K beats (rank 0..K-1) on out_*.
//   clear_start/clear_done : fill array with SENTINEL / done pulse
//   wr_valid/wr_ready, wr_addr, wr_data : writer request (K entries)
//   rd_start, rd_base, rd_count, rd_busy, rd_done : readout control
//   out_valid/out_ready, out_data, out_addr, out_rank : beat stream
//   csb0, web0, addr0, wdata0 : SRAM port0 (registered, active-low)
//   csb1, addr1, rdata1       : SRAM port1 (registered, per-bank select)
//
// Write FSM
//   state   | meaning
//   IDLE    | accepting writer requests, one SRAM write per handshake
//   CLEAR   | writing SENTINEL to addresses 0..DEPTH-1, writer held off
// Read FSM
//   state   | meaning
//   R_IDLE  | no readout
//   R_RUN   | issuing port1 reads, rank-major within each address
//   R_DRAIN | all reads issued, waiting for the last beat to be accepted
module kbest_array_ctrl
  import kbest_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_start,
  output logic                           clear_done,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [K-1:0][DATA_WIDTH-1:0]   wr_data,
  input  logic                           rd_start,
  input  logic [ADDR_WIDTH-1:0]          rd_base,
  input  logic [ADDR_WIDTH:0]            rd_count,
  output logic                           rd_busy,
  output logic                           rd_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic [RANK_W-1:0]              out_rank,
  output logic                           csb0,
  output logic                           web0,
  output logic [ADDR_WIDTH-1:0]          addr0,
  output logic [K-1:0][DATA_WIDTH-1:0]   wdata0,
  output logic [K-1:0]                   csb1,
  output logic [ADDR_WIDTH-1:0]          addr1,
  input  logic [K-1:0][DATA_WIDTH-1:0]   rdata1
);

  wr_state_e wr_state, wr_state_n;
  rd_state_e rd_state, rd_state_n;

  logic                         wr_rdy_q, clear_go, wr_fire, clear_done_n;
  logic [ADDR_WIDTH-1:0]        clr_cnt, clr_cnt_n;
  logic                         csb0_n, web0_n;
  logic [ADDR_WIDTH-1:0]        addr0_n;
  logic [K-1:0][DATA_WIDTH-1:0] wdata0_n;

  logic                  rd_go, hazard, issue, pop, rd_done_n;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_n, addr1_n;
  logic [RANK_W-1:0]     rd_rank, rd_rank_n;
  logic [BEAT_W-1:0]     beats_left, beats_left_n;
  logic [K-1:0]          csb1_n;
  logic [2:0]            occ_after;
  logic [1:0]            skid_cnt;

  // Read pipeline: iss_* is the cycle port1 is selected, cap_* the cycle rdata1 is valid.
  logic                  iss_v, cap_v;
  logic [ADDR_WIDTH-1:0] iss_addr, cap_addr;
  logic [RANK_W-1:0]     iss_rank, cap_rank;
  beat_t                 cap_beat, head;

  // ---------------- write path ----------------
  always_comb begin
    wr_state_n   = wr_state;
    clr_cnt_n    = clr_cnt;
    csb0_n       = 1'b1;
    web0_n       = 1'b1;
    addr0_n      = addr0;
    wdata0_n     = wdata0;
    clear_done_n = 1'b0;
    clear_go     = clear_start && (wr_state == IDLE) && (rd_state == R_IDLE);
    // Gated so a write handshake can never collide with the first clear write.
    wr_ready     = wr_rdy_q && !clear_go;
    wr_fire      = wr_valid && wr_ready;
    case (wr_state)
      IDLE: begin
        if (clear_go) begin
          wr_state_n = CLEAR;
          clr_cnt_n  = ADDR_WIDTH'(DEPTH - 1);
          csb0_n     = 1'b0;
          web0_n     = 1'b0;
          addr0_n    = '0;
          wdata0_n   = {K{SENTINEL}};
        end else if (wr_fire) begin
          csb0_n   = 1'b0;
          web0_n   = 1'b0;
          addr0_n  = wr_addr;
          wdata0_n = wr_data;
        end
      end
      CLEAR: begin
        if (clr_cnt == '0) begin
          wr_state_n   = IDLE;
          clear_done_n = 1'b1;
        end else begin
          clr_cnt_n = clr_cnt - 1'b1;
          csb0_n    = 1'b0;
          web0_n    = 1'b0;
          addr0_n   = addr0 + 1'b1;
          wdata0_n  = {K{SENTINEL}};
        end
      end
      default: wr_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state   <= IDLE;
      clr_cnt    <= '0;
      wr_rdy_q   <= 1'b0;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      wdata0     <= '0;
      clear_done <= 1'b0;
    end else begin
      wr_state   <= wr_state_n;
      clr_cnt    <= clr_cnt_n;
      wr_rdy_q   <= (wr_state_n == IDLE);
      csb0       <= csb0_n;
      web0       <= web0_n;
      addr0      <= addr0_n;
      wdata0     <= wdata0_n;
      clear_done <= clear_done_n;
    end
  end

  // ---------------- readout ----------------
  always_comb begin
    rd_state_n   = rd_state;
    rd_addr_n    = rd_addr;
    rd_rank_n    = rd_rank;
    beats_left_n = beats_left;
    csb1_n       = '1;
    addr1_n      = addr1;
    rd_done_n    = 1'b0;
    issue        = 1'b0;
    rd_go        = rd_start && (rd_state == R_IDLE) && (wr_state == IDLE) &&
                   !clear_start && (rd_count != '0);
    pop          = out_valid && out_ready;
    // Skid occupancy plus reads still in the SRAM pipeline, after this cycle's pop.
    occ_after    = 3'(skid_cnt) + 3'(cap_v) + 3'(iss_v) - 3'(pop);
    // Read and write of the same address in one cycle would return stale data.
    hazard       = !csb0_n && !web0_n && (addr0_n == rd_addr);
    case (rd_state)
      R_IDLE: begin
        if (rd_go) begin
          rd_state_n   = R_RUN;
          rd_addr_n    = rd_base;
          rd_rank_n    = '0;
          beats_left_n = BEAT_W'(rd_count) * BEAT_W'(K);
        end
      end
      R_RUN: begin
        if ((occ_after < 3'd2) && !hazard) begin
          issue        = 1'b1;
          csb1_n       = bank_sel_b(rd_rank);
          addr1_n      = rd_addr;
          beats_left_n = beats_left - 1'b1;
          if (rd_rank == RANK_W'(K - 1)) begin
            rd_rank_n = '0;
            rd_addr_n = rd_addr + 1'b1;
          end else begin
            rd_rank_n = rd_rank + 1'b1;
          end
          if (beats_left == BEAT_W'(1)) rd_state_n = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (!iss_v && !cap_v && (occ_after == 3'd0)) begin
          rd_state_n = R_IDLE;
          rd_done_n  = 1'b1;
        end
      end
      default: rd_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state   <= R_IDLE;
      rd_addr    <= '0;
      rd_rank    <= '0;
      beats_left <= '0;
      csb1       <= '1;
      addr1      <= '0;
      rd_busy    <= 1'b0;
      rd_done    <= 1'b0;
      iss_v      <= 1'b0;
      iss_addr   <= '0;
      iss_rank   <= '0;
      cap_v      <= 1'b0;
      cap_addr   <= '0;
      cap_rank   <= '0;
    end else begin
      rd_state   <= rd_state_n;
      rd_addr    <= rd_addr_n;
      rd_rank    <= rd_rank_n;
      beats_left <= beats_left_n;
      csb1       <= csb1_n;
      addr1      <= addr1_n;
      rd_busy    <= (rd_state_n != R_IDLE);
      rd_done    <= rd_done_n;
      iss_v      <= issue;
      if (issue) begin
        iss_addr <= rd_addr;
        iss_rank <= rd_rank;
      end
      cap_v      <= iss_v;
      cap_addr   <= iss_addr;
      cap_rank   <= iss_rank;
    end
  end

  assign cap_beat = '{data: rdata1[cap_rank], addr: cap_addr, rank: cap_rank};

  kbest_out_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (cap_v),
    .in_beat   (cap_beat),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_beat  (head),
    .count     (skid_cnt)
  );

  assign out_data = head.data;
  assign out_addr = head.addr;
  assign out_rank = head.rank;

endmodule

// File: tb/tb_kbest_array_ctrl.sv
module tb_kbest_array_ctrl;
  import kbest_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst = 1'b1;
  logic                         clear_start = 1'b0, clear_done;
  logic                         wr_valid = 1'b0, wr_ready;
  logic [ADDR_WIDTH-1:0]        wr_addr = '0;
  logic [K-1:0][DATA_WIDTH-1:0] wr_data = '0;
  logic                         rd_start = 1'b0;
  logic [ADDR_WIDTH-1:0]        rd_base = '0;
  logic [ADDR_WIDTH:0]          rd_count = '0;
  logic                         rd_busy, rd_done, out_valid;
  logic                         out_ready = 1'b1;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [ADDR_WIDTH-1:0]        out_addr;
  logic [RANK_W-1:0]            out_rank;
  logic                         csb0, web0;
  logic [ADDR_WIDTH-1:0]        addr0, addr1;
  logic [K-1:0][DATA_WIDTH-1:0] wdata0;
  logic [K-1:0]                 csb1;
  logic [K-1:0][DATA_WIDTH-1:0] rdata1 = '0;

  kbest_array_ctrl dut (
    .clk(clk), .rst(rst),
    .clear_start(clear_start), .clear_done(clear_done),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_count(rd_count),
    .rd_busy(rd_busy), .rd_done(rd_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_rank(out_rank),
    .csb0(csb0), .web0(web0), .addr0(addr0), .wdata0(wdata0),
    .csb1(csb1), .addr1(addr1), .rdata1(rdata1)
  );

  // SRAM model: same-cycle read of a location being written returns old data.
  logic [DATA_WIDTH-1:0] mem [K][DEPTH];
  always @(posedge clk) begin
    for (int b = 0; b < K; b++) begin
      if (!csb0 && !web0) mem[b][addr0] <= wdata0[b];
      if (!csb1[b])       rdata1[b]     <= mem[b][addr1];
    end
  end

  logic [DATA_WIDTH-1:0] ref_mem [K][DEPTH];
  beat_t exp_q [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_beats = 0;
  logic  bp_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic [31:0] d, input logic [7:0] a, input logic [1:0] r);
    beat_t b;
    b.data = d; b.addr = a; b.rank = r;
    return b;
  endfunction

  // Scoreboard monitor: pops on each accepted beat, checks stall stability.
  initial begin : monitor
    beat_t e;
    logic [63:0] prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 64'(out_valid), 64'(1));
          chk("stall_stable", 64'({out_data, out_addr, out_rank}), prev);
        end
        if (out_valid && out_ready) begin
          n_beats++;
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL beat_unexpected: got addr %0d rank %0d data %0h, expected no beat",
                     out_addr, out_rank, out_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat", 64'({out_data, out_addr, out_rank}), 64'(e));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev = 64'({out_data, out_addr, out_rank});
      end
    end
  end

  // Port-level checks whenever port1 is selected.
  initial begin : port_mon
    forever begin
      @(negedge clk);
      if (!rst && (csb1 != '1)) begin
        chk("csb1_onehot", 64'($countones(~csb1)), 64'(1));
        if (!csb0 && !web0) chk("rw_same_addr", 64'(addr1 != addr0), 64'(1));
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [K-1:0][DATA_WIDTH-1:0] d);
    int w;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    w = 0;
    @(negedge clk);
    while (!wr_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!wr_ready) begin
      n_tests++; n_fail++;
      $display("FAIL wr_ready_timeout: got 0, expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    for (int b = 0; b < K; b++) ref_mem[b][a] = d[b];
  endtask

  task automatic start_read(input logic [7:0] base, input int count, input bit use_model);
    logic [7:0] a;
    if (use_model) begin
      for (int i = 0; i < count; i++) begin
        a = 8'(base + 8'(i));
        for (int r = 0; r < K; r++) exp_q.push_back(mk(ref_mem[r][a], a, 2'(r)));
      end
    end
    rd_start = 1'b1; rd_base = base; rd_count = 9'(count);
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_rd_done(input int max, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (rd_done) begin
        seen = 1'b1;
        chk({name, "_busy_fall"}, 64'(rd_busy), 64'(0));
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL %s_rd_done_timeout: got no rd_done, expected one within %0d cycles", name, max);
    end
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_csb0"}, 64'(csb0), 64'(1));
    chk({name, "_web0"}, 64'(web0), 64'(1));
    chk({name, "_csb1"}, 64'(csb1), 64'(4'hF));
    chk({name, "_addr0"}, 64'(addr0), 64'(0));
    chk({name, "_addr1"}, 64'(addr1), 64'(0));
    chk({name, "_wdata0_zero"}, 64'(wdata0 == '0), 64'(1));
    chk({name, "_wr_ready"}, 64'(wr_ready), 64'(0));
    chk({name, "_clear_done"}, 64'(clear_done), 64'(0));
    chk({name, "_rd_busy"}, 64'(rd_busy), 64'(0));
    chk({name, "_rd_done"}, 64'(rd_done), 64'(0));
    chk({name, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({name, "_out_fields"}, 64'({out_data, out_addr, out_rank}), 64'(0));
  endtask

  task automatic run_clear(input string name, output bit saw_busy);
    int n;
    bit seen;
    n = 0; seen = 1'b0; saw_busy = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (rd_busy) saw_busy = 1'b1;
      if (n == 10) chk({name, "_wr_ready_low"}, 64'(wr_ready), 64'(0));
      if (clear_done) seen = 1'b1;
    end
    chk({name, "_done_latency"}, 64'(n), 64'(257));
    @(negedge clk);
    chk({name, "_done_pulse"}, 64'(clear_done), 64'(0));
    for (int b = 0; b < K; b++)
      for (int a = 0; a < DEPTH; a++) ref_mem[b][a] = SENTINEL;
    tick();
  endtask

  initial begin : main
    logic [K-1:0][DATA_WIDTH-1:0] d;
    bit busy_flag;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("wr_ready_idle", 64'(wr_ready), 64'(1));

    // Clear, then full-array readout of SENTINEL
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    run_clear("clear", busy_flag);
    n_beats = 0;
    start_read(8'd0, 256, 1'b1);
    wait_rd_done(8000, "clear_read");
    chk("clear_read_beats", 64'(n_beats), 64'(1024));

    // Write then read one address, hand-computed beats
    d[0] = 32'd10; d[1] = 32'd20; d[2] = 32'd30; d[3] = 32'd40;
    do_write(8'd5, d);
    exp_q.push_back(mk(32'd10, 8'd5, 2'd0));
    exp_q.push_back(mk(32'd20, 8'd5, 2'd1));
    exp_q.push_back(mk(32'd30, 8'd5, 2'd2));
    exp_q.push_back(mk(32'd40, 8'd5, 2'd3));
    n_beats = 0;
    start_read(8'd5, 1, 1'b0);
    wait_rd_done(200, "wr_rd");
    chk("wr_rd_beats", 64'(n_beats), 64'(4));

    // Address wrap 254, 255, 0
    for (int a = 254; a < 257; a++) begin
      for (int r = 0; r < K; r++) d[r] = {16'hA5A5, 8'(a), 8'(r)};
      do_write(8'(a), d);
    end
    n_beats = 0;
    start_read(8'd254, 3, 1'b1);
    wait_rd_done(300, "wrap");
    chk("wrap_beats", 64'(n_beats), 64'(12));

    // Hazard: writer hits addr 7 in the cycle the first read would issue
    d[0] = 32'h0101; d[1] = 32'h0202; d[2] = 32'h0303; d[3] = 32'h0404;
    do_write(8'd7, d);
    exp_q.push_back(mk(32'h7777_0000, 8'd7, 2'd0));
    exp_q.push_back(mk(32'h7777_0001, 8'd7, 2'd1));
    exp_q.push_back(mk(32'h7777_0002, 8'd7, 2'd2));
    exp_q.push_back(mk(32'h7777_0003, 8'd7, 2'd3));
    n_beats = 0;
    rd_start = 1'b1; rd_base = 8'd7; rd_count = 9'd1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    wr_valid = 1'b1; wr_addr = 8'd7;
    for (int r = 0; r < K; r++) wr_data[r] = 32'h7777_0000 | 32'(r);
    @(negedge clk);
    chk("wr_ready_during_read", 64'(wr_ready), 64'(1));
    @(posedge clk); #1;
    wr_valid = 1'b0;
    for (int r = 0; r < K; r++) ref_mem[r][7] = 32'h7777_0000 | 32'(r);
    wait_rd_done(200, "hazard");
    chk("hazard_beats", 64'(n_beats), 64'(4));

    // Backpressure: out_ready high 30% of cycles
    for (int a = 20; a < 24; a++) begin
      for (int r = 0; r < K; r++) d[r] = {8'hB0, 8'(a), 8'(r), 8'h5C};
      do_write(8'(a), d);
    end
    n_beats = 0;
    bp_mode = 1'b1;
    start_read(8'd20, 4, 1'b1);
    wait_rd_done(3000, "backpressure");
    bp_mode = 1'b0;
    chk("backpressure_beats", 64'(n_beats), 64'(16));

    // Reset mid-readout
    start_read(8'd0, 256, 1'b1);
    repeat (60) tick();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("mid_rst");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // clear_start and rd_start together: clear wins
    clear_start = 1'b1; rd_start = 1'b1; rd_base = 8'd0; rd_count = 9'd4;
    @(posedge clk); #1;
    clear_start = 1'b0; rd_start = 1'b0;
    run_clear("prio", busy_flag);
    chk("prio_rd_busy_never", 64'(busy_flag), 64'(0));
    repeat (20) @(negedge clk);
    chk("prio_no_readout", 64'(rd_busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
